// File: rtl/lc3_pkg.sv
// Shared LC3 decode definitions.
//
// Holds the opcode enumeration, the enums for the ALU/PC-select/writeback
// control fields, the bit positions inside the 6-bit E_Control bus, the
// de_valid FSM state type and the list of opcodes treated as illegal.
//
// Optional feature macro referenced by users of this package:
//   LC3_DECODE_ILLEGAL_CHK_EN  (illegal-opcode detection)
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_NOT = 2'b10
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    PCS1_NONE   = 2'b00,
    PCS1_OFF9   = 2'b01,
    PCS1_OFF6   = 2'b10,
    PCS1_BASE   = 2'b11
  } pcsel1_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_PC  = 2'b01,
    WB_MEM = 2'b10
  } wb_sel_t;

  // de_valid FSM: CAP means the previous edge captured an instruction.
  typedef enum logic {
    DV_IDLE = 1'b0,
    DV_CAP  = 1'b1
  } dv_state_t;

  // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int E_ALU_MSB = 5;
  localparam int E_ALU_LSB = 4;
  localparam int E_PS1_MSB = 3;
  localparam int E_PS1_LSB = 2;
  localparam int E_PS2_BIT = 1;
  localparam int E_OP2_BIT = 0;

  localparam int N_ILLEGAL = 4;
  localparam logic [3:0] ILLEGAL_OPS [N_ILLEGAL] = '{OP_JSR, OP_RTI, OP_RES, OP_TRAP};

  function automatic logic is_illegal_op(input logic [3:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_ILLEGAL; i++) begin
      if (op == ILLEGAL_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational LC3 opcode decoder.
//
// Maps the 4-bit opcode plus instruction bit 5 (immediate flag for ADD/AND)
// to the execute, writeback and memory controls.
//
// Ports:
//   opcode    in  4   instruction bits [15:12]
//   imm_bit   in  1   instruction bit 5
//   e_ctrl    out 6   {alu[1:0], pcselect1[1:0], pcselect2, op2select}
//   w_ctrl    out 2   writeback select (0 ALU, 1 PC, 2 memory)
//   mem_ctrl  out 1   indirect access (LDI/STI)
//   illegal   out 1   only present with LC3_DECODE_ILLEGAL_CHK_EN
//
// Macro: LC3_DECODE_ILLEGAL_CHK_EN adds the illegal output.
module lc3_decode_ctrl
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       imm_bit,
  output logic [5:0] e_ctrl,
  output logic [1:0] w_ctrl,
`ifdef LC3_DECODE_ILLEGAL_CHK_EN
  output logic       illegal,
`endif
  output logic       mem_ctrl
);

  alu_ctrl_t alu;
  pcsel1_t   ps1;
  logic      ps2;
  logic      op2;
  wb_sel_t   wb;

  always_comb begin
    alu      = ALU_ADD;
    ps1      = PCS1_NONE;
    ps2      = 1'b0;
    op2      = 1'b0;
    wb       = WB_ALU;
    mem_ctrl = 1'b0;
    case (opcode_t'(opcode))
      // op2select=1 selects the register operand, so it is the inverse
      // of the immediate flag.
      OP_ADD: begin alu = ALU_ADD; op2 = ~imm_bit; end
      OP_AND: begin alu = ALU_AND; op2 = ~imm_bit; end
      OP_NOT: begin alu = ALU_NOT; op2 = 1'b1; end
      OP_BR:  begin ps1 = PCS1_OFF9; ps2 = 1'b1; end
      OP_JMP: begin ps1 = PCS1_BASE; ps2 = 1'b0; end
      OP_LD:  begin ps1 = PCS1_OFF9; ps2 = 1'b1; wb = WB_MEM; end
      OP_LDI: begin ps1 = PCS1_OFF9; ps2 = 1'b1; wb = WB_MEM; mem_ctrl = 1'b1; end
      OP_LDR: begin ps1 = PCS1_OFF6; ps2 = 1'b0; wb = WB_MEM; end
      OP_LEA: begin ps1 = PCS1_OFF9; ps2 = 1'b1; wb = WB_PC; end
      OP_ST:  begin ps1 = PCS1_OFF9; ps2 = 1'b1; end
      OP_STI: begin ps1 = PCS1_OFF9; ps2 = 1'b1; mem_ctrl = 1'b1; end
      OP_STR: begin ps1 = PCS1_OFF6; ps2 = 1'b0; end
      default: ; // JSR, RTI, reserved, TRAP: all controls 0
    endcase
  end

  always_comb begin
    e_ctrl = '0;
    e_ctrl[E_ALU_MSB:E_ALU_LSB] = alu;
    e_ctrl[E_PS1_MSB:E_PS1_LSB] = ps1;
    e_ctrl[E_PS2_BIT]           = ps2;
    e_ctrl[E_OP2_BIT]           = op2;
  end

  assign w_ctrl = wb;

`ifdef LC3_DECODE_ILLEGAL_CHK_EN
  assign illegal = is_illegal_op(opcode);
`endif

endmodule

// File: rtl/lc3_decode_stage.sv
// LC3 pipeline decode stage.
//
// Captures the fetched instruction and next PC when en_decode is high and
// registers the decoded execute/writeback/memory controls. Also produces a
// one-cycle-after-capture valid flag (de_valid, which is the FSM state made
// visible) and a wrapping capture counter.
//
// Handshake: en_decode is a plain per-cycle enable; every posedge with
// en_decode=1 is one capture, no backpressure exists.
//
// Ports:
//   clock, reset (async, active-high)
//   en_decode, dout[15:0], npc_in[15:0]            inputs from fetch/control
//   IR, npc_out, E_Control[5:0], W_Control[1:0],
//   Mem_Control, de_valid, instr_count, illegal_op outputs
//
// Macro: LC3_DECODE_ILLEGAL_CHK_EN enables illegal-opcode detection;
// otherwise illegal_op is tied to 0.
module lc3_decode_stage
  import lc3_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int IR_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en_decode,
  input  logic [IR_W-1:0]    dout,
  input  logic [IR_W-1:0]    npc_in,
  output logic [IR_W-1:0]    IR,
  output logic [IR_W-1:0]    npc_out,
  output logic [5:0]         E_Control,
  output logic [1:0]         W_Control,
  output logic               Mem_Control,
  output logic               de_valid,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal_op
);

  logic [5:0] e_next;
  logic [1:0] w_next;
  logic       mem_next;

  dv_state_t state_q;
  dv_state_t state_d;

`ifdef LC3_DECODE_ILLEGAL_CHK_EN
  logic ill_next;
`endif

  lc3_decode_ctrl u_ctrl (
    .opcode   (dout[IR_W-1 -: 4]),
    .imm_bit  (dout[5]),
    .e_ctrl   (e_next),
    .w_ctrl   (w_next),
`ifdef LC3_DECODE_ILLEGAL_CHK_EN
    .illegal  (ill_next),
`endif
    .mem_ctrl (mem_next)
  );

  // Instruction, PC, control and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IR          <= '0;
      npc_out     <= '0;
      E_Control   <= '0;
      W_Control   <= '0;
      Mem_Control <= 1'b0;
      instr_count <= '0;
    end else if (en_decode) begin
      IR          <= dout;
      npc_out     <= npc_in;
      E_Control   <= e_next;
      W_Control   <= w_next;
      Mem_Control <= mem_next;
      instr_count <= instr_count + COUNT_W'(1);
    end
  end

  // de_valid FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= DV_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DV_IDLE: if (en_decode)  state_d = DV_CAP;
      DV_CAP:  if (!en_decode) state_d = DV_IDLE;
      default: state_d = DV_IDLE;
    endcase
  end

  assign de_valid = (state_q == DV_CAP);

`ifdef LC3_DECODE_ILLEGAL_CHK_EN
  // The decode table already zeroes controls for these opcodes, so only
  // the flag itself needs a register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          illegal_op <= 1'b0;
    else if (en_decode) illegal_op <= ill_next;
  end
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Self-checking bench for lc3_decode_stage: directed scenarios plus random
// captures, compared against a behavioural model of the decode table.
module tb_lc3_decode_stage;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic en_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  always #5 clock = ~clock;

  logic [15:0] ir, npc_out;
  logic [5:0]  e_control;
  logic [1:0]  w_control;
  logic        mem_control, de_valid, illegal_op;
  logic [15:0] instr_count;

  logic [15:0] s_ir, s_npc;
  logic [5:0]  s_e;
  logic [1:0]  s_w;
  logic        s_mem, s_valid, s_ill;
  logic [3:0]  s_count;

  lc3_decode_stage #(.COUNT_W(16), .IR_W(16)) dut (
    .clock(clock), .reset(reset), .en_decode(en_decode), .dout(dout),
    .npc_in(npc_in), .IR(ir), .npc_out(npc_out), .E_Control(e_control),
    .W_Control(w_control), .Mem_Control(mem_control), .de_valid(de_valid),
    .instr_count(instr_count), .illegal_op(illegal_op)
  );

  // Narrow-counter instance, used for the wrap check.
  lc3_decode_stage #(.COUNT_W(4), .IR_W(16)) dut_small (
    .clock(clock), .reset(reset), .en_decode(en_decode), .dout(dout),
    .npc_in(npc_in), .IR(s_ir), .npc_out(s_npc), .E_Control(s_e),
    .W_Control(s_w), .Mem_Control(s_mem), .de_valid(s_valid),
    .instr_count(s_count), .illegal_op(s_ill)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected snapshot: {IR16, NPC16, E6, W2, MEM1, VALID1, ILL1}
  logic [42:0] exp_q[$];

  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_mem, m_valid, m_ill;
  int          m_cnt;

  // Returns {E[5:0], W[1:0], Mem}; fields combined arithmetically.
  function automatic logic [8:0] ref_ctrl(input logic [15:0] instr);
    int alu, ps1, ps2, op2, wb, mem, e;
    alu = 0; ps1 = 0; ps2 = 0; op2 = 0; wb = 0; mem = 0;
    case (int'(instr[15:12]))
      1:  begin alu = 0; op2 = instr[5] ? 0 : 1; end
      5:  begin alu = 1; op2 = instr[5] ? 0 : 1; end
      9:  begin alu = 2; op2 = 1; end
      0:  begin ps1 = 1; ps2 = 1; end
      12: begin ps1 = 3; end
      2:  begin ps1 = 1; ps2 = 1; wb = 2; end
      10: begin ps1 = 1; ps2 = 1; wb = 2; mem = 1; end
      6:  begin ps1 = 2; wb = 2; end
      14: begin ps1 = 1; ps2 = 1; wb = 1; end
      3:  begin ps1 = 1; ps2 = 1; end
      11: begin ps1 = 1; ps2 = 1; mem = 1; end
      7:  begin ps1 = 2; end
      default: ;
    endcase
    e = alu * 16 + ps1 * 4 + ps2 * 2 + op2;
    return {6'(e), 2'(wb), 1'(mem)};
  endfunction

  function automatic logic ref_illegal(input logic [15:0] instr);
`ifdef LC3_DECODE_ILLEGAL_CHK_EN
    int op;
    op = int'(instr[15:12]);
    return (op == 4) || (op == 8) || (op == 13) || (op == 15);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_ir = '0; m_npc = '0; m_e = '0; m_w = '0;
    m_mem = 1'b0; m_valid = 1'b0; m_ill = 1'b0; m_cnt = 0;
    exp_q.delete();
  endtask

  // Applied at each posedge with the inputs seen there.
  task automatic model_edge(input logic en, input logic [15:0] d, input logic [15:0] n);
    logic [8:0] c;
    if (en) begin
      c = ref_ctrl(d);
      m_ir = d; m_npc = n;
      m_e = c[8:3]; m_w = c[2:1]; m_mem = c[0];
      m_ill = ref_illegal(d);
      m_cnt = m_cnt + 1;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    exp_q.push_back({m_ir, m_npc, m_e, m_w, m_mem, m_valid, m_ill});
  endtask

  task automatic compare_outputs(input string tag);
    logic [42:0] x;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    x = exp_q.pop_front();
    check({tag, "_ir"},    32'(ir),          32'(x[42:27]));
    check({tag, "_npc"},   32'(npc_out),     32'(x[26:11]));
    check({tag, "_e"},     32'(e_control),   32'(x[10:5]));
    check({tag, "_w"},     32'(w_control),   32'(x[4:3]));
    check({tag, "_mem"},   32'(mem_control), 32'(x[2]));
    check({tag, "_valid"}, 32'(de_valid),    32'(x[1]));
    check({tag, "_ill"},   32'(illegal_op),  32'(x[0]));
    check({tag, "_cnt"},   32'(instr_count), 32'(m_cnt % 65536));
    check({tag, "_cnt4"},  32'(s_count),     32'(m_cnt % 16));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ir"},    32'(ir),          32'd0);
    check({tag, "_npc"},   32'(npc_out),     32'd0);
    check({tag, "_e"},     32'(e_control),   32'd0);
    check({tag, "_w"},     32'(w_control),   32'd0);
    check({tag, "_mem"},   32'(mem_control), 32'd0);
    check({tag, "_valid"}, 32'(de_valid),    32'd0);
    check({tag, "_ill"},   32'(illegal_op),  32'd0);
    check({tag, "_cnt"},   32'(instr_count), 32'd0);
    check({tag, "_cnt4"},  32'(s_count),     32'd0);
    model_reset();
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; drives, lets one posedge happen, checks at the
  // following negedge.
  task automatic step(input logic en, input logic [15:0] d, input logic [15:0] n, input string tag);
    en_decode = en; dout = d; npc_in = n;
    @(posedge clock);
    model_edge(en, d, n);
    @(negedge clock);
    compare_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] saved_ir;
    logic [15:0] rnd;
    reset = 1'b1; en_decode = 1'b0; dout = '0; npc_in = '0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_zero("por");

    // Release reset with en_decode already high: next edge captures.
    reset = 1'b0;
    step(1'b1, 16'h1283, 16'h3001, "add_reg");
    check("tp_add_e", 32'(e_control), 32'b000001);
    check("tp_add_ir", 32'(ir), 32'h1283);
    check("tp_add_cnt", 32'(instr_count), 32'd1);

    step(1'b1, 16'hA405, 16'h3002, "ldi");
    check("tp_ldi_e", 32'(e_control), 32'b000110);
    check("tp_ldi_w", 32'(w_control), 32'd2);
    check("tp_ldi_mem", 32'(mem_control), 32'd1);
    check("tp_ldi_valid", 32'(de_valid), 32'd1);

    step(1'b1, 16'h1262, 16'h3003, "add_imm");
    check("tp_addi_e", 32'(e_control), 32'b000000);
    check("tp_addi_valid", 32'(de_valid), 32'd1);

    for (int i = 0; i < 3; i++) step(1'b0, 16'($urandom), 16'($urandom), "hold");
    check("tp_hold_ir", 32'(ir), 32'h1262);
    check("tp_hold_cnt", 32'(instr_count), 32'd3);

    // 16 captures: the 4-bit counter passes 15 -> 0 along the way.
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom), 16'($urandom), "wrap");
    check("tp_wrap_cnt4", 32'(s_count), 32'd3);

    step(1'b1, 16'hD000, 16'h4000, "illegal");
    check("tp_ill_ir", 32'(ir), 32'hD000);
    check("tp_ill_e", 32'(e_control), 32'd0);
`ifdef LC3_DECODE_ILLEGAL_CHK_EN
    check("tp_ill_flag", 32'(illegal_op), 32'd1);
`else
    check("tp_ill_flag", 32'(illegal_op), 32'd0);
`endif
    step(1'b0, 16'h1000, 16'h0, "ill_hold");

    // Random mix; every opcode appears with high probability.
    for (int i = 0; i < 300; i++) begin
      rnd = 16'($urandom);
      step($urandom_range(0, 9) < 7, rnd, 16'($urandom), "rand");
    end

    // Asynchronous reset mid-cycle, then reset dominating en_decode.
    step(1'b1, 16'h1283, 16'h5555, "pre_rst");
    saved_ir = ir;
    check("pre_rst_ir", 32'(saved_ir), 32'h1283);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    en_decode = 1'b1; dout = 16'hA405; npc_in = 16'h1111;
    @(posedge clock);
    @(negedge clock);
    check_zero("rst_wins");
    reset = 1'b0;
    step(1'b1, 16'h6123, 16'h2222, "post_rst");
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom), "tail");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_decode_stage.md
Name: lc3_decode_stage

Overview:
- RTL decode stage of the LC3 pipeline; drives the decode_out interface that the decode_out agent samples.
- Captures the fetched instruction and next-PC when `en_decode` is high, then produces registered execute/memory/writeback controls.
- Sits between the fetch stage (source of `dout` and `npc_in`) and the execute/writeback stages.
- Adds a capture-valid pulse and a decoded-instruction counter for pipeline bookkeeping.

Parameters:
- `COUNT_W`, default 16: width of `instr_count`.
- `IR_W`, default 16: instruction/PC width. Fixed by the LC3 ISA; exposed only for package consistency.

Ports:
- `clock`  in  1  pipeline clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en_decode`  in  1  capture enable from the pipeline controller.
- `dout`  in  16  instruction word from fetch.
- `npc_in`  in  16  next PC from fetch.
- `IR`  out  16  registered instruction.
- `npc_out`  out  16  registered next PC.
- `E_Control`  out  6  packed as {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `W_Control`  out  2  writeback select: 0 = ALU, 1 = PC (LEA), 2 = memory.
- `Mem_Control`  out  1  set to 1 for indirect (LDI/STI) accesses.
- `de_valid`  out  1  high for the cycle after each capture.
- `instr_count`  out  COUNT_W  number of captures, wraps.
- `illegal_op`  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): every output is cleared to 0, including `IR`, `npc_out`, all controls, `de_valid`, `instr_count` and `illegal_op`.
- Capture: at a posedge with `en_decode`=1, all outputs are loaded from `dout`/`npc_in` in the same edge.
  - Latency is one cycle; outputs are stable by the following negedge, where the agent samples.
- Hold: at a posedge with `en_decode`=0, `IR`, `npc_out` and all controls keep their values. `de_valid` is cleared to 0.
- `de_valid` state machine has two states:
  - IDLE → CAP on a capture.
  - CAP → CAP on a back-to-back capture, so `de_valid` stays 1.
  - CAP → IDLE when `en_decode`=0.
- `instr_count` increments by 1 on each capture, modulo 2^COUNT_W: all-ones wraps to 0.
- Decode is a function of `dout[15:12]`. Unlisted fields are 0.
  - ADD (0001): alu=00; op2select=~dout[5]; W=0.
  - AND (0101): alu=01; op2select=~dout[5]; W=0.
  - NOT (1001): alu=10; op2select=1; W=0.
  - BR (0000): pcselect1=01; pcselect2=1.
  - JMP (1100): pcselect1=11; pcselect2=0.
  - LD (0010) / LDI (1010): pcselect1=01; pcselect2=1; W=2.
  - LDR (0110): pcselect1=10; pcselect2=0; W=2.
  - LEA (1110): pcselect1=01; pcselect2=1; W=1.
  - ST (0011) / STI (1011): pcselect1=01; pcselect2=1.
  - STR (0111): pcselect1=10; pcselect2=0.
  - `Mem_Control`=1 only for LDI and STI.
  - Opcodes 0100, 1000, 1101, 1111: all controls 0.
- Simultaneous `reset` and `en_decode`: reset wins.
- `en_decode` asserted in the same cycle reset deasserts: the next posedge captures normally.

Optional Feature:
- Macro: `LC3_DECODE_ILLEGAL_CHK_EN`.
- Defined:
  - At a capture, `illegal_op` is registered to 1 for opcodes 0100, 1000, 1101 and 1111, and to 0 otherwise.
  - All controls are forced to 0.
  - `IR`, `npc_out` and `instr_count` still update.
  - `illegal_op` holds its value while `en_decode`=0.
- Undefined: `illegal_op` is tied to 0 and no detection logic is built.

Decomposition:
- Shared package `lc3_pkg` holds:
  - `opcode_t` enum;
  - `alu_ctrl_t`, `pcsel1_t` and `wb_sel_t` enums;
  - the `E_Control` field-position constants;
  - the list of illegal opcodes.
- Sub-module `lc3_decode_ctrl`: purely combinational mapping from opcode plus `dout[5]` to {E, W, Mem, illegal}.
- The top level holds the registers, the FSM and the counter.

Test Plan:
- Assert `reset` mid-run with `IR`=16'h1283 → all outputs read 0 before the next clock edge.
- `en_decode`=1, `dout`=16'h1283, `npc_in`=16'h3001 → next posedge: `IR`=1283, `npc_out`=3001, `E_Control`=6'b000001, W=0, Mem=0, `de_valid`=1, `instr_count`=1.
- Back-to-back captures of `dout`=16'hA405 (LDI) then 16'h1262 (ADD immediate):
  - after the LDI edge: `E_Control`=6'b000110, W=2, Mem=1;
  - after the ADD edge: `E_Control`=6'b000000, W=0, Mem=0;
  - `de_valid` stays 1 throughout.
- `en_decode`=0 for 3 cycles while `dout` toggles → `IR`, `npc_out` and controls hold; `de_valid`=0 from the first idle edge; count unchanged.
- With `COUNT_W`=4, perform 16 captures → `instr_count` wraps 15 → 0.
- `dout`=16'hD000 with `LC3_DECODE_ILLEGAL_CHK_EN` defined → `illegal_op`=1, controls 0, `IR`=D000. Without the macro → `illegal_op`=0.
